// File: rtl/disp_msg_sched.sv
// disp_msg_sched: message scheduler for a 3-digit 7-segment display.
// Generates the digit-scan strobe, holds error messages for a fixed number
// of scan ticks, and keeps the latest value in a shadow register so the
// display can return to it once an error message expires.
module disp_msg_sched #(
  parameter int SCAN_DIV   = 100000,
  parameter int HOLD_SCANS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        err_req,
  input  logic [1:0]  err_code,
  input  logic        val_req,
  input  logic [11:0] val_data,
  input  logic [1:0]  val_kind,
  input  logic        clr,
  output logic        scan_tick,
  output logic [11:0] disp_x,
  output logic [2:0]  disp_mode,
  output logic        disp_dp,
  output logic        busy
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int HW = $clog2(HOLD_SCANS + 1);
  localparam logic [PW-1:0] CNT_LAST  = PW'(SCAN_DIV - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_SCANS);

  localparam logic [2:0] MODE_BLANK    = 3'd0;
  localparam logic [2:0] MODE_CODE_ERR = 3'd4;
  localparam logic [2:0] MODE_USD_ERR  = 3'd5;
  localparam logic [2:0] MODE_FMT_ERR  = 3'd6;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHOW_VAL = 2'd1,
    SHOW_ERR = 2'd2
  } state_t;

  state_t        state, next_state;
  logic [PW-1:0] cnt, cnt_nxt;
  logic [HW-1:0] hold, next_hold;
  logic [2:0]    err_mode, next_err_mode;
  logic [11:0]   shadow_x, next_shadow_x;
  logic [1:0]    shadow_kind, next_shadow_kind;
  logic          shadow_valid, next_shadow_valid;

  logic [11:0]   disp_x_d;
  logic [2:0]    disp_mode_d;
  logic          disp_dp_d;
  logic          busy_d;

  logic          kind_ok, digits_ok, val_ok, fmt_err, code_err_ok, any_err;
  logic [2:0]    err_mode_in;

  assign cnt_nxt = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;

  assign kind_ok     = (val_kind != 2'd3);
  assign digits_ok   = (val_data[11:8] <= 4'd9) && (val_data[7:4] <= 4'd9) &&
                       (val_data[3:0] <= 4'd9);
  assign val_ok      = val_req && kind_ok && digits_ok;
  assign fmt_err     = val_req && kind_ok && !digits_ok;
  assign code_err_ok = err_req && ((err_code == 2'd1) || (err_code == 2'd2));
  assign any_err     = code_err_ok || fmt_err;
  assign err_mode_in = code_err_ok ? ((err_code == 2'd1) ? MODE_CODE_ERR : MODE_USD_ERR)
                                   : MODE_FMT_ERR;

  // Free-running scan prescaler; the strobe is registered so it is high exactly while cnt is at its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      scan_tick <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      scan_tick <= (cnt_nxt == CNT_LAST);
    end
  end

  // State register: FSM state, hold counter, latched error kind and value shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      hold         <= '0;
      err_mode     <= MODE_BLANK;
      shadow_x     <= '0;
      shadow_kind  <= '0;
      shadow_valid <= 1'b0;
    end else begin
      state        <= next_state;
      hold         <= next_hold;
      err_mode     <= next_err_mode;
      shadow_x     <= next_shadow_x;
      shadow_kind  <= next_shadow_kind;
      shadow_valid <= next_shadow_valid;
    end
  end

  // Next-state logic: clr beats errors, errors beat values, and a held error only expires after the hold runs out.
  always_comb begin
    next_state        = state;
    next_hold         = hold;
    next_err_mode     = err_mode;
    next_shadow_x     = shadow_x;
    next_shadow_kind  = shadow_kind;
    next_shadow_valid = shadow_valid;

    if (clr) begin
      next_state        = IDLE;
      next_hold         = '0;
      next_shadow_valid = 1'b0;
    end else begin
      if (val_ok) begin
        next_shadow_x     = val_data;
        next_shadow_kind  = val_kind;
        next_shadow_valid = 1'b1;
      end

      if (any_err) begin
        next_state    = SHOW_ERR;
        next_hold     = HOLD_LOAD;
        next_err_mode = err_mode_in;
      end else begin
        case (state)
          SHOW_ERR: begin
            if (hold == '0) begin
              next_state = next_shadow_valid ? SHOW_VAL : IDLE;
            end else if (scan_tick) begin
              next_hold = hold - 1'b1;
            end
          end
          IDLE, SHOW_VAL: begin
            if (val_ok) begin
              next_state = SHOW_VAL;
            end
          end
          default: begin
            next_state = IDLE;
            next_hold  = '0;
          end
        endcase
      end
    end
  end

  // Output decode from the upcoming state so the registered outputs follow a request with one cycle of latency.
  always_comb begin
    disp_x_d    = '0;
    disp_mode_d = MODE_BLANK;
    disp_dp_d   = 1'b0;
    busy_d      = 1'b0;
    case (next_state)
      SHOW_VAL: begin
        disp_x_d    = next_shadow_x;
        disp_mode_d = {1'b0, next_shadow_kind} + 3'd1;
        disp_dp_d   = (next_shadow_kind == 2'd1) || (next_shadow_kind == 2'd2);
      end
      SHOW_ERR: begin
        disp_mode_d = next_err_mode;
        busy_d      = 1'b1;
      end
      default: begin
        disp_mode_d = MODE_BLANK;
      end
    endcase
  end

  // Output register for the display driver interface.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_x    <= '0;
      disp_mode <= MODE_BLANK;
      disp_dp   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      disp_x    <= disp_x_d;
      disp_mode <= disp_mode_d;
      disp_dp   <= disp_dp_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_disp_msg_sched.sv
// tb_disp_msg_sched: scoreboard bench for disp_msg_sched with SCAN_DIV=4, HOLD_SCANS=3.
module tb_disp_msg_sched;

  logic        clk;
  logic        rst_n;
  logic        err_req;
  logic [1:0]  err_code;
  logic        val_req;
  logic [11:0] val_data;
  logic [1:0]  val_kind;
  logic        clr;
  logic        scan_tick;
  logic [11:0] disp_x;
  logic [2:0]  disp_mode;
  logic        disp_dp;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0]  mode;
    logic [11:0] x;
    logic        dp;
    logic        busy;
  } exp_t;

  exp_t sb[$];

  disp_msg_sched #(.SCAN_DIV(4), .HOLD_SCANS(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .err_req   (err_req),
    .err_code  (err_code),
    .val_req   (val_req),
    .val_data  (val_data),
    .val_kind  (val_kind),
    .clr       (clr),
    .scan_tick (scan_tick),
    .disp_x    (disp_x),
    .disp_mode (disp_mode),
    .disp_dp   (disp_dp),
    .busy      (busy)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic popCheck(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checkOutput({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      checkOutput({tag, "_mode"}, 32'(disp_mode), 32'(e.mode));
      checkOutput({tag, "_x"},    32'(disp_x),    32'(e.x));
      checkOutput({tag, "_dp"},   32'(disp_dp),   32'(e.dp));
      checkOutput({tag, "_busy"}, 32'(busy),      32'(e.busy));
    end
  endtask

  task automatic applyStimulus(input string tag,
                               input logic er, input logic [1:0] ec,
                               input logic vr, input logic [11:0] vd, input logic [1:0] vk,
                               input logic cl,
                               input logic [2:0] m, input logic [11:0] x,
                               input logic dp, input logic b);
    exp_t e;
    @(negedge clk);
    err_req  = er;
    err_code = ec;
    val_req  = vr;
    val_data = vd;
    val_kind = vk;
    clr      = cl;
    e.mode = m;
    e.x    = x;
    e.dp   = dp;
    e.busy = b;
    sb.push_back(e);
    @(posedge clk);
    #1;
    err_req  = 1'b0;
    err_code = 2'd0;
    val_req  = 1'b0;
    val_data = 12'h000;
    val_kind = 2'd0;
    clr      = 1'b0;
    popCheck(tag);
  endtask

  task automatic waitTicks(input string tag, input int n);
    int seen = 0;
    int cyc  = 0;
    while (seen < n && cyc < 60) begin
      if (scan_tick === 1'b1) seen++;
      @(posedge clk);
      #1;
      cyc++;
    end
    checkOutput({tag, "_ticks_seen"}, 32'(seen), 32'(n));
    checkOutput({tag, "_still_busy"}, 32'(busy), 32'd1);
  endtask

  task automatic waitHold(input string tag, input int expTicks,
                          input logic [2:0] m, input logic [11:0] x, input logic dp);
    exp_t e;
    int   seen = 0;
    int   cyc  = 0;
    e.mode = m;
    e.x    = x;
    e.dp   = dp;
    e.busy = 1'b0;
    sb.push_back(e);
    while (busy === 1'b1 && cyc < 60) begin
      if (scan_tick === 1'b1) seen++;
      @(posedge clk);
      #1;
      cyc++;
    end
    if (expTicks >= 0) checkOutput({tag, "_hold_ticks"}, 32'(seen), 32'(expTicks));
    popCheck(tag);
  endtask

  // Main sequence: reset, prescaler phase, then the display scenarios.
  initial begin
    rst_n    = 1'b0;
    err_req  = 1'b0;
    err_code = 2'd0;
    val_req  = 1'b0;
    val_data = 12'h000;
    val_kind = 2'd0;
    clr      = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_tick", 32'(scan_tick), 32'd0);
    checkOutput("rst_mode", 32'(disp_mode), 32'd0);
    checkOutput("rst_x",    32'(disp_x),    32'd0);
    checkOutput("rst_dp",   32'(disp_dp),   32'd0);
    checkOutput("rst_busy", 32'(busy),      32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("tick_c1", 32'(scan_tick), 32'd0);
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("tick_c%0d", k + 1), 32'(scan_tick), (k % 4 == 3) ? 32'd1 : 32'd0);
      checkOutput($sformatf("idle_mode_c%0d", k + 1), 32'(disp_mode), 32'd0);
    end

    applyStimulus("price",    0, 2'd0, 1, 12'h125, 2'd1, 0, 3'd2, 12'h125, 1, 0);
    applyStimulus("kind3",    0, 2'd0, 1, 12'h999, 2'd3, 0, 3'd2, 12'h125, 1, 0);
    applyStimulus("code0",    1, 2'd0, 0, 12'h000, 2'd0, 0, 3'd2, 12'h125, 1, 0);
    applyStimulus("code3",    1, 2'd3, 0, 12'h000, 2'd0, 0, 3'd2, 12'h125, 1, 0);
    applyStimulus("usd_err",  1, 2'd2, 0, 12'h000, 2'd0, 0, 3'd5, 12'h000, 0, 1);
    waitHold("usd_exit", 3, 3'd2, 12'h125, 1);

    applyStimulus("clr",      0, 2'd0, 0, 12'h000, 2'd0, 1, 3'd0, 12'h000, 0, 0);
    applyStimulus("fmt_err",  0, 2'd0, 1, 12'h1A0, 2'd2, 0, 3'd6, 12'h000, 0, 1);
    waitHold("fmt_exit", 3, 3'd0, 12'h000, 0);

    applyStimulus("reload_a", 1, 2'd2, 0, 12'h000, 2'd0, 0, 3'd5, 12'h000, 0, 1);
    waitTicks("reload_wait", 2);
    applyStimulus("reload_b", 1, 2'd1, 0, 12'h000, 2'd0, 0, 3'd4, 12'h000, 0, 1);
    waitHold("reload_exit", 3, 3'd0, 12'h000, 0);

    applyStimulus("bg_err",   1, 2'd1, 0, 12'h000, 2'd0, 0, 3'd4, 12'h000, 0, 1);
    applyStimulus("bg_val",   0, 2'd0, 1, 12'h789, 2'd0, 0, 3'd4, 12'h000, 0, 1);
    waitHold("bg_exit", -1, 3'd1, 12'h789, 0);

    applyStimulus("both",     1, 2'd2, 1, 12'h321, 2'd2, 0, 3'd5, 12'h000, 0, 1);
    waitHold("both_exit", 3, 3'd3, 12'h321, 1);

    applyStimulus("clr_all",  1, 2'd1, 1, 12'h050, 2'd0, 1, 3'd0, 12'h000, 0, 0);
    applyStimulus("after_clr", 1, 2'd1, 0, 12'h000, 2'd0, 0, 3'd4, 12'h000, 0, 1);
    waitHold("after_clr_exit", 3, 3'd0, 12'h000, 0);

    applyStimulus("code_val", 0, 2'd0, 1, 12'h050, 2'd0, 0, 3'd1, 12'h050, 0, 0);
    applyStimulus("max_bcd",  0, 2'd0, 1, 12'h999, 2'd1, 0, 3'd2, 12'h999, 1, 0);
    applyStimulus("low_nib",  0, 2'd0, 1, 12'h90A, 2'd0, 0, 3'd6, 12'h000, 0, 1);
    waitHold("low_nib_exit", 3, 3'd2, 12'h999, 1);

    applyStimulus("pre_rst",  1, 2'd2, 0, 12'h000, 2'd0, 0, 3'd5, 12'h000, 0, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", 32'(busy),      32'd0);
    checkOutput("midrst_mode", 32'(disp_mode), 32'd0);
    checkOutput("midrst_tick", 32'(scan_tick), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("rel_tick_c%0d", k + 1), 32'(scan_tick), (k == 3) ? 32'd1 : 32'd0);
    end
    checkOutput("rel_busy", 32'(busy), 32'd0);
    checkOutput("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
